// File: rtl/avalon_st_tx_pkt_fifo.sv
// avalon_st_tx_pkt_fifo
// Store-and-forward packet FIFO between the traffic generator Avalon-ST TX
// output and the MAC TX input. A packet becomes visible on the output only
// after its EOP beat is stored, so out_valid never drops inside a packet.
// Malformed packets (new SOP before EOP) and packets larger than the buffer
// are discarded and counted.
//
// Ports
//   clk, reset_n                      clock, async active-low reset
//   in_data/empty/sop/eop/error       generator beat, qualified by in_valid
//   in_valid, in_ready                input handshake
//   out_data/empty/sop/eop/error      beat toward MAC TX
//   out_valid, out_ready              output handshake (ready latency 0)
//   level                             stored entries (committed + in-flight)
//   pkt_fwd_count                     packets sent (wraps)
//   pkt_drop_count                    packets dropped (saturates)
module avalon_st_tx_pkt_fifo #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned AW    = 9
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [63:0]   in_data,
  input  logic [2:0]    in_empty,
  input  logic          in_sop,
  input  logic          in_eop,
  input  logic          in_error,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [63:0]   out_data,
  output logic [2:0]    out_empty,
  output logic          out_sop,
  output logic          out_eop,
  output logic          out_error,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW:0]   level,
  output logic [31:0]   pkt_fwd_count,
  output logic [15:0]   pkt_drop_count
);

  localparam int unsigned DW = 64;
  localparam int unsigned EW = 3;
  localparam int unsigned PW = AW + 1;
  localparam logic [AW:0] DEPTH_P = PW'(DEPTH);

  typedef struct packed {
    logic          error;
    logic          eop;
    logic          sop;
    logic [EW-1:0] empty;
    logic [DW-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PKT     = 2'd1,
    ST_DISCARD = 2'd2
  } state_e;

  entry_t mem [0:DEPTH-1];
  entry_t rd_entry_q;
  entry_t wr_entry;
  entry_t out_q, out_d;

  state_e        state_q, state_d;
  logic [AW:0]   wp_q, wp_d;          // next write slot
  logic [AW:0]   cp_q, cp_d;          // start of packet being received
  logic [AW:0]   rd_ptr_q, rd_ptr_d;  // next RAM read address
  logic [AW:0]   rp_q, rp_d;          // release pointer: beats handed to MAC
  logic [AW:0]   committed_q, committed_d;
  logic [AW:0]   level_q, level_d;
  logic [31:0]   fwd_q, fwd_d;
  logic [15:0]   drop_q, drop_d;
  logic          in_ready_q, in_ready_d;
  logic          rd_vld_q, rd_vld_d;
  logic          out_valid_q, out_valid_d;

  logic          accept;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [AW:0]   base;
  logic          commit;
  logic          drop;
  logic          full;
  logic          out_fire;
  logic          pkt_done;
  logic          s1_adv;
  logic          rd_en;

  assign full     = (level_q == DEPTH_P);
  assign accept   = in_valid & in_ready_q;
  assign wr_entry = '{error: in_error, eop: in_eop, sop: in_sop,
                      empty: in_empty, data: in_data};

  // Input FSM: writes, commits, rewinds and drops
  always_comb begin
    state_d = state_q;
    wp_d    = wp_q;
    cp_d    = cp_q;
    wr_en   = 1'b0;
    wr_addr = wp_q[AW-1:0];
    base    = wp_q;
    commit  = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept && in_sop) begin
          wr_en = 1'b1;
          wp_d  = wp_q + PW'(1);
          if (in_eop) begin
            cp_d   = wp_q + PW'(1);
            commit = 1'b1;
          end else begin
            state_d = ST_PKT;
          end
        end
      end
      ST_PKT: begin
        if (full && (committed_q == '0)) begin
          // packet alone fills the buffer: can never complete
          wp_d    = cp_q;
          drop    = 1'b1;
          state_d = ST_DISCARD;
        end else if (accept) begin
          // a fresh SOP abandons the partial packet and restarts at cp
          base    = in_sop ? cp_q : wp_q;
          drop    = in_sop;
          wr_en   = 1'b1;
          wr_addr = base[AW-1:0];
          wp_d    = base + PW'(1);
          if (in_eop) begin
            cp_d    = base + PW'(1);
            commit  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_DISCARD: begin
        if (accept && in_eop) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read pipeline (RAM read stage + output register), counters, level
  always_comb begin
    out_fire    = out_valid_q & out_ready;
    pkt_done    = out_fire & out_q.eop;
    s1_adv      = rd_vld_q & (~out_valid_q | out_ready);
    // only beats below cp belong to committed packets
    rd_en       = (rd_ptr_q != cp_q) & (~rd_vld_q | s1_adv);
    rd_ptr_d    = rd_en ? rd_ptr_q + PW'(1) : rd_ptr_q;
    rd_vld_d    = rd_en | (rd_vld_q & ~s1_adv);
    out_valid_d = s1_adv | (out_valid_q & ~out_ready);
    out_d       = s1_adv ? rd_entry_q : out_q;
    rp_d        = out_fire ? rp_q + PW'(1) : rp_q;

    committed_d = committed_q;
    unique case ({commit, pkt_done})
      2'b10:   committed_d = committed_q + PW'(1);
      2'b01:   committed_d = committed_q - PW'(1);
      default: committed_d = committed_q;
    endcase

    fwd_d  = pkt_done ? fwd_q + 32'd1 : fwd_q;
    drop_d = (drop && (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;

    level_d    = wp_d - rp_d;
    in_ready_d = (state_d == ST_DISCARD) || (level_d != DEPTH_P);
  end

  // Packet RAM: one write port, one registered read port
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_entry;
    if (rd_en) rd_entry_q <= mem[rd_ptr_q[AW-1:0]];
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      wp_q        <= '0;
      cp_q        <= '0;
      rd_ptr_q    <= '0;
      rp_q        <= '0;
      committed_q <= '0;
      level_q     <= '0;
      fwd_q       <= '0;
      drop_q      <= '0;
      in_ready_q  <= 1'b0;
      rd_vld_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      wp_q        <= wp_d;
      cp_q        <= cp_d;
      rd_ptr_q    <= rd_ptr_d;
      rp_q        <= rp_d;
      committed_q <= committed_d;
      level_q     <= level_d;
      fwd_q       <= fwd_d;
      drop_q      <= drop_d;
      in_ready_q  <= in_ready_d;
      rd_vld_q    <= rd_vld_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = out_valid_q;
  assign out_data       = out_q.data;
  assign out_empty      = out_q.empty;
  assign out_sop        = out_q.sop;
  assign out_eop        = out_q.eop;
  assign out_error      = out_q.error;
  assign level          = level_q;
  assign pkt_fwd_count  = fwd_q;
  assign pkt_drop_count = drop_q;

endmodule

// File: tb/tb_avalon_st_tx_pkt_fifo.sv
// Bench for avalon_st_tx_pkt_fifo (DEPTH=16). A packet-level reference model
// decides which beats must appear on the output; a negedge monitor drives
// out_ready and compares every delivered beat.
module tb_avalon_st_tx_pkt_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  typedef logic [69:0] beat_t;  // {error, eop, sop, empty[2:0], data[63:0]}

  logic          clk = 1'b0;
  logic          reset_n;
  logic [63:0]   in_data;
  logic [2:0]    in_empty;
  logic          in_sop, in_eop, in_error, in_valid;
  logic          in_ready;
  logic [63:0]   out_data;
  logic [2:0]    out_empty;
  logic          out_sop, out_eop, out_error, out_valid;
  logic          out_ready = 1'b0;
  logic [AW:0]   level;
  logic [31:0]   pkt_fwd_count;
  logic [15:0]   pkt_drop_count;

  avalon_st_tx_pkt_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_data(in_data), .in_empty(in_empty), .in_sop(in_sop), .in_eop(in_eop),
    .in_error(in_error), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_empty(out_empty), .out_sop(out_sop),
    .out_eop(out_eop), .out_error(out_error), .out_valid(out_valid),
    .out_ready(out_ready), .level(level), .pkt_fwd_count(pkt_fwd_count),
    .pkt_drop_count(pkt_drop_count)
  );

  always #5 clk = ~clk;

  beat_t exp_q[$];      // beats of complete packets not yet delivered
  beat_t cur_q[$];      // packet currently being received
  bit    discarding = 1'b0;
  int    exp_fwd = 0, exp_drop = 0;
  int    n_cmp = 0, n_err = 0;
  int    cyc = 0;
  int    rdy_mode = 1;  // 0: out_ready low, 1: high, 2: random
  bit    gaps = 1'b0;
  bit    sop_seen = 1'b0;
  int    sop_cyc = 0, last_eop_edge = 0;
  bit    hold_q = 1'b0, pkt_open = 1'b0;
  beat_t hold_obs = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t mk(input bit err, input bit eop, input bit sop,
                               input logic [2:0] emp, input logic [63:0] d);
    return {err, eop, sop, emp, d};
  endfunction

  task automatic note_drop();
    if (exp_drop < 65535) exp_drop++;
  endtask

  task automatic commit_cur();
    foreach (cur_q[i]) exp_q.push_back(cur_q[i]);
    cur_q.delete();
  endtask

  // Packet rules applied to one accepted beat
  task automatic model_accept(input beat_t b);
    bit sop, eop;
    sop = b[67];
    eop = b[68];
    if (discarding) begin
      if (eop) discarding = 1'b0;
    end else if (sop) begin
      if (cur_q.size() != 0) note_drop();
      cur_q.delete();
      cur_q.push_back(b);
      if (eop) commit_cur();
    end else if (cur_q.size() != 0) begin
      cur_q.push_back(b);
      if (eop) commit_cur();
      else if (cur_q.size() == int'(DEPTH)) begin
        note_drop();
        cur_q.delete();
        discarding = 1'b1;
      end
    end
  endtask

  // Called at a negedge; returns at the negedge after acceptance
  task automatic send_beat(input beat_t b);
    bit done;
    done = 1'b0;
    if (gaps && ($urandom_range(0, 3) == 0)) @(negedge clk);
    {in_error, in_eop, in_sop, in_empty, in_data} = b;
    in_valid = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      if (in_ready === 1'b1) begin
        model_accept(b);
        if (b[68]) last_eop_edge = cyc + 1;
        done = 1'b1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("accept_timeout", 70'(done), 70'(1));
  endtask

  task automatic send_pkt(input int len, input bit trunc);
    for (int i = 0; i < len; i++) begin
      send_beat(mk(($urandom_range(0, 7) == 0), (i == len - 1) && !trunc, (i == 0),
                   3'($urandom_range(0, 7)), {$urandom, $urandom}));
    end
  endtask

  task automatic wait_drain();
    int i;
    i = 0;
    while ((exp_q.size() != 0 || out_valid === 1'b1) && i < 3000) begin
      @(negedge clk);
      i++;
    end
    repeat (2) @(negedge clk);
    check("drain", 70'(exp_q.size()), 70'(0));
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_fwd"},   70'(pkt_fwd_count),  70'(exp_fwd));
    check({tag, "_drop"},  70'(pkt_drop_count), 70'(exp_drop));
    check({tag, "_level"}, 70'(level),          70'(cur_q.size()));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"},  70'(in_ready),  70'(0));
    check({tag, "_out_valid"}, 70'(out_valid), 70'(0));
    check({tag, "_out_beat"},  {out_error, out_eop, out_sop, out_empty, out_data}, 70'(0));
    check({tag, "_level"},     70'(level),          70'(0));
    check({tag, "_fwd"},       70'(pkt_fwd_count),  70'(0));
    check({tag, "_drop"},      70'(pkt_drop_count), 70'(0));
  endtask

  // Output monitor: drives out_ready, checks order, hold and continuity
  always @(negedge clk) begin
    beat_t obs, e;
    obs = {out_error, out_eop, out_sop, out_empty, out_data};
    if (reset_n !== 1'b1) begin
      hold_q    = 1'b0;
      pkt_open  = 1'b0;
      out_ready = 1'b0;
    end else begin
      if (hold_q) begin
        check("hold_stable", obs, hold_obs);
        check("hold_valid", 70'(out_valid), 70'(1));
      end
      if (pkt_open) check("valid_gap", 70'(out_valid), 70'(1));
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (out_valid === 1'b1 && out_sop === 1'b1 && !sop_seen) begin
        sop_seen = 1'b1;
        sop_cyc  = cyc;
      end
      if (out_valid === 1'b1 && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 70'(exp_q.size()), 70'(1));
        end else begin
          e = exp_q.pop_front();
          check("beat", obs, e);
          if (e[68]) exp_fwd++;
        end
        pkt_open = (out_eop !== 1'b1);
      end
      hold_q   = (out_valid === 1'b1) && !out_ready;
      hold_obs = obs;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fwd_before;
    beat_t b;
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_empty = '0;
    in_sop = 1'b0; in_eop = 1'b0; in_error = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_reset_vals("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 70'(in_ready), 70'(1));

    // Single 8-beat packet, empty=3 on EOP
    rdy_mode = 1; gaps = 1'b0; sop_seen = 1'b0;
    for (int i = 0; i < 8; i++)
      send_beat(mk(1'b0, (i == 7), (i == 0), (i == 7) ? 3'd3 : 3'd0, {$urandom, $urandom}));
    wait_drain();
    check("sop_latency", 70'(sop_cyc - last_eop_edge), 70'(2));
    check("single_fwd_const", 70'(pkt_fwd_count), 70'(1));
    check_counters("single");

    // 100 x 4-beat packets with random output backpressure
    rdy_mode = 2;
    for (int p = 0; p < 100; p++) send_pkt(4, 1'b0);
    rdy_mode = 1;
    wait_drain();
    check_counters("backpressure");

    // Oversize: 20-beat packet dropped, 2-beat packet forwarded
    fwd_before = exp_fwd;
    send_pkt(20, 1'b0);
    send_pkt(2, 1'b0);
    wait_drain();
    check("oversize_drop", 70'(pkt_drop_count), 70'(1));
    check("oversize_fwd", 70'(pkt_fwd_count), 70'(fwd_before + 1));
    check_counters("oversize");

    // Malformed: 2-beat fragment then a 3-beat packet
    send_pkt(2, 1'b1);
    send_pkt(3, 1'b0);
    wait_drain();
    check("malformed_drop", 70'(pkt_drop_count), 70'(2));
    check_counters("malformed");

    // Full FIFO with output stalled
    rdy_mode = 0;
    @(negedge clk);
    fwd_before = exp_fwd;
    for (int p = 0; p < 4; p++) send_pkt(4, 1'b0);
    @(negedge clk);
    check("full_level", 70'(level), 70'(DEPTH));
    check("full_ready", 70'(in_ready), 70'(0));
    rdy_mode = 1;
    wait_drain();
    check("full_fwd", 70'(pkt_fwd_count), 70'(fwd_before + 4));
    check_counters("full");

    // Random mix: stray beats, truncated packets, input gaps, random ready
    rdy_mode = 2; gaps = 1'b1;
    for (int p = 0; p < 60; p++) begin
      if ($urandom_range(0, 9) == 0)
        send_beat(mk(1'b0, 1'($urandom_range(0, 1)), 1'b0, 3'd0, {$urandom, $urandom}));
      send_pkt(int'($urandom_range(1, 6)), (p != 59) && ($urandom_range(0, 7) == 0));
    end
    rdy_mode = 1; gaps = 1'b0;
    wait_drain();
    check_counters("random");

    // Reset during beat 3 of a 6-beat packet
    send_beat(mk(1'b0, 1'b0, 1'b1, 3'd0, {$urandom, $urandom}));
    send_beat(mk(1'b0, 1'b0, 1'b0, 3'd0, {$urandom, $urandom}));
    b = mk(1'b0, 1'b0, 1'b0, 3'd0, {$urandom, $urandom});
    {in_error, in_eop, in_sop, in_empty, in_data} = b;
    in_valid = 1'b1;
    #2 reset_n = 1'b0;
    #1 check_reset_vals("midreset");
    exp_q.delete(); cur_q.delete(); discarding = 1'b0;
    exp_fwd = 0; exp_drop = 0;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("midreset_ready", 70'(in_ready), 70'(1));
    send_pkt(2, 1'b0);
    wait_drain();
    check("midreset_fwd", 70'(pkt_fwd_count), 70'(1));
    check_counters("midreset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/avalon_st_tx_pkt_fifo.md
# avalon_st_tx_pkt_fifo

Store-and-forward packet FIFO between the traffic generator's Avalon-ST TX output and the MAC TX input. It accepts generator beats under backpressure and releases a packet only once its EOP beat is stored, so `out_valid` never drops mid-packet toward the MAC. It discards packets that are malformed or larger than the buffer, and exposes occupancy and forward/drop counters to the monitor CSR space.

## Interface
- `DEPTH`, 512: buffer entries; power of two, ≥ 16.
- `AW`, 9: log2(DEPTH).
- `clk` in 1: single clock for all logic.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_data` in 64: beat data from generator.
- `in_empty` in 3: empty bytes; meaningful on EOP only.
- `in_sop`, `in_eop`, `in_error` in 1 each: packet delimiters and error flag.
- `in_valid` in 1: beat valid.
- `in_ready` out 1: beat accepted when `in_valid & in_ready`.
- `out_data` out 64, `out_empty` out 3, `out_sop`/`out_eop`/`out_error` out 1 each: toward MAC TX.
- `out_valid` out 1, `out_ready` in 1: ready-latency-0 handshake.
- `level` out AW+1: stored entries, committed plus uncommitted.
- `pkt_fwd_count` out 32: packets whose EOP left the output; wraps.
- `pkt_drop_count` out 16: dropped packets; saturates at 0xFFFF.

## Operation
- **Storage:** entry = {error, eop, sop, empty, data} (70 bits) in simple dual-port RAM.
- **Pointers:** write pointer `wp`, commit pointer `cp` (start of current input packet) and read pointer `rp`, each AW+1 bits, compared modulo 2^(AW+1).
- **Counters:** `full` = (`wp`−`rp`) == DEPTH. `committed` counter = number of complete packets held.
- **Input FSM states:** IDLE, PKT, DISCARD.
  - IDLE: accepted beat with sop → write it, go to PKT; if sop & eop, commit immediately and stay IDLE. Beat without sop → discard silently; no count.
  - PKT: accepted beat is written. eop → `cp` ← `wp`+1, `committed`++, go to IDLE. sop (no eop) → rewind `wp` ← `cp`, `pkt_drop_count`++, write the new beat as a fresh packet start; remain PKT. sop & eop → same rewind and drop, then commit the single beat, go to IDLE.
  - Oversize: in PKT, `full` and `committed`==0 → rewind `wp` ← `cp`, `pkt_drop_count`++, go to DISCARD.
  - DISCARD: `in_ready`=1, beats are thrown away; an accepted eop → IDLE.
- **`in_ready`:** (!`full`) in IDLE/PKT, 1 in DISCARD, 0 in reset.
- **Output:** a one-entry prefetch register feeds `out_*`. `out_valid` is asserted only while the register holds a beat belonging to a committed packet. Read from RAM when `committed`>0 and the register is empty or being consumed. Accepted eop → `committed`−−, `pkt_fwd_count`++.
- **Simultaneous events:** commit and release in the same cycle leave `committed` unchanged. Write and read in the same cycle leave `level` unchanged.
- `in_error` is stored and forwarded unchanged; it does not cause a drop.

## Timing
- **Reset values:** `in_ready`=0, `out_valid`=0, `out_sop`/`out_eop`/`out_error`=0, `out_data`=0, `out_empty`=0, `level`=0, both counters 0, FSM=IDLE, all pointers 0. `in_ready` goes to 1 on the first clk edge after reset is released.
- **Latency:** eop accepted at edge N → `out_valid`=1 with sop at edge N+2 (empty FIFO, `out_ready`=1).
- **Throughput:** with `out_ready` held high, one beat per cycle, and `out_valid` stays continuous across a stored packet.
- **Backpressure:** `out_*` hold stable while `out_valid & !out_ready`.
- **Counter timing:** `level` is updated one cycle after the accept or release that changes it. Counters update in the cycle after the qualifying handshake.
- **Reset mid-operation:** all contents and the in-flight packet are discarded. Counters are cleared.

## Test plan
- **Single packet:** 8-beat packet, empty=3 on eop, `out_ready`=1 → identical 8 beats out, first out_sop 2 cycles after in_eop, `pkt_fwd_count`=1.
- **Output backpressure:** 100 back-to-back 4-beat packets, `out_ready` toggling randomly → all 400 beats in order, `out_valid` never low inside a packet, `level` returns to 0.
- **Oversize drop:** DEPTH=16; 20-beat packet followed by a 2-beat packet → first dropped (`pkt_drop_count`=1), only the 2-beat packet appears, `level`=0 at end.
- **Malformed sop:** sop, 2 beats, then a new sop…eop (3 beats) → first fragment dropped (`pkt_drop_count`=1), the 3-beat packet forwarded.
- **Full FIFO:** DEPTH=16, `out_ready`=0, feed 4×4-beat packets → `in_ready`=0 at `level`=16. Release `out_ready` → all 16 beats forwarded, `pkt_fwd_count`=4.
- **Reset mid-packet:** assert `reset_n`=0 during beat 3 of 6 → all outputs at reset values immediately. After release, a new 2-beat packet is forwarded alone.
